pc_fetch_control: RTL and testbench

//  Program-counter register and next-PC selection for the fetch stage. Drives PCResult

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_fetch_control_if.sv | 27 ++
 rtl/pc_redirect_hold.sv | 41 ++++
 rtl/pc_fetch_control.sv | 102 ++++++++++
 tb/tb_pc_fetch_control.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants, select encoding and helpers for the fetch PC
package pc_pkg;
  localparam int          PC_WIDTH         = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Next-PC source select, in increasing priority order
  localparam logic [1:0]  SEL_SEQ     = 2'd0;
  localparam logic [1:0]  SEL_BRANCH  = 2'd1;
  localparam logic [1:0]  SEL_JUMP    = 2'd2;
  localparam logic [1:0]  SEL_PENDING = 2'd3;

  // BOOT covers the single edge after reset where the reset PC is fetched unchanged
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Clear the byte-offset bits so a redirect always lands on an instruction boundary
  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
    return addr & ~PC_WIDTH'(INSTR_BYTES - 1);
  endfunction
endpackage

// File: rtl/pc_fetch_control_if.sv
// rtl/pc_fetch_control_if.sv - fetch-stage PC control signal bundle
interface pc_fetch_control_if;
  import pc_pkg::*;

  logic [PC_WIDTH-1:0] PCAddResult;
  logic                BranchTaken;
  logic [PC_WIDTH-1:0] BranchTarget;
  logic                Jump;
  logic [PC_WIDTH-1:0] JumpTarget;
  logic                Stall;
  logic [PC_WIDTH-1:0] PCResult;
  logic                FetchValid;
  logic                Flush;
  logic                Misaligned;

  // master: the PC controller itself
  modport master (
    input  PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
    output PCResult, FetchValid, Flush, Misaligned
  );

  // slave: the pipeline around it (adder, hazard unit, branch/jump resolution)
  modport slave (
    output PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
    input  PCResult, FetchValid, Flush, Misaligned
  );
endinterface

// File: rtl/pc_redirect_hold.sv
// rtl/pc_redirect_hold.sv - holds one redirect target captured while fetch is stalled
module pc_redirect_hold
  import pc_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                capture_en_i,
  input  logic [PC_WIDTH-1:0] capture_target_i,
  input  logic                release_i,
  output logic                pend_valid_o,
  output logic [PC_WIDTH-1:0] pend_target_o
);
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] target_q, target_d;

  // First capture wins; later requests are ignored until the hold is released
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (release_i) begin
      valid_d = 1'b0;
    end else if (capture_en_i && !valid_q) begin
      valid_d  = 1'b1;
      target_d = capture_target_i;
    end
  end

  // Pending register; reset discards any held redirect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_target_o = target_q;
endmodule

// File: rtl/pc_fetch_control.sv
// rtl/pc_fetch_control.sv - fetch PC register with redirect arbitration, stall and flush
module pc_fetch_control
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  pc_fetch_control_if.master  bus
);
  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                flush_q, flush_d;
  logic                mis_q, mis_d;

  logic [1:0]          sel;
  logic [PC_WIDTH-1:0] raw_tgt;
  logic                redirect;
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_target;
  logic                capture_en;
  logic [PC_WIDTH-1:0] capture_target;
  logic                release_pend;

  // A redirect seen during a stall is parked; any unstalled running edge consumes it
  assign capture_en     = (state_q == ST_RUN) && bus.Stall && (bus.Jump || bus.BranchTaken);
  assign capture_target = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
  assign release_pend   = (state_q == ST_RUN) && !bus.Stall;

  pc_redirect_hold u_hold (
    .Clk              (Clk),
    .Reset            (Reset),
    .capture_en_i     (capture_en),
    .capture_target_i (capture_target),
    .release_i        (release_pend),
    .pend_valid_o     (pend_valid),
    .pend_target_o    (pend_target)
  );

  // Priority select: older pending redirect, then jump, then branch, then PC+4
  always_comb begin
    sel = SEL_SEQ;
    if (pend_valid)           sel = SEL_PENDING;
    else if (bus.Jump)        sel = SEL_JUMP;
    else if (bus.BranchTaken) sel = SEL_BRANCH;
    case (sel)
      SEL_PENDING: raw_tgt = pend_target;
      SEL_JUMP:    raw_tgt = bus.JumpTarget;
      SEL_BRANCH:  raw_tgt = bus.BranchTarget;
      default:     raw_tgt = bus.PCAddResult;
    endcase
    redirect = (sel != SEL_SEQ);
  end

  // Next-state and output decode; pulses default low so they last one cycle
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    mis_d         = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.Stall) begin
          if (redirect) begin
            pc_d    = align_word(raw_tgt);
            flush_d = 1'b1;
            mis_d   = ALIGN_CHECK && (raw_tgt[1:0] != 2'b00);
          end else begin
            pc_d    = raw_tgt;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
    fetch_valid_d = (state_d == ST_RUN);
  end

  // State and output flops
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      mis_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      mis_q         <= mis_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.FetchValid = fetch_valid_q;
  assign bus.Flush      = flush_q;
  assign bus.Misaligned = mis_q;
endmodule

// File: tb/tb_pc_fetch_control.sv
// tb/tb_pc_fetch_control.sv - self-checking bench for pc_fetch_control
module tb_pc_fetch_control;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        br, j, st;
  logic [31:0] bt, jt;

  pc_fetch_control_if ifa ();
  pc_fetch_control_if ifb ();

  assign ifa.PCAddResult  = ifa.PCResult + 32'd4;
  assign ifa.BranchTaken  = br;
  assign ifa.BranchTarget = bt;
  assign ifa.Jump         = j;
  assign ifa.JumpTarget   = jt;
  assign ifa.Stall        = st;
  assign ifb.PCAddResult  = ifb.PCResult + 32'd4;
  assign ifb.BranchTaken  = br;
  assign ifb.BranchTarget = bt;
  assign ifb.Jump         = j;
  assign ifb.JumpTarget   = jt;
  assign ifb.Stall        = st;

  pc_fetch_control #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b1)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(ifa.master));
  pc_fetch_control #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b0)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(ifb.master));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: what fetch must do, in terms of pending/live redirect requests
  logic [31:0] m_pc, m_pend_tgt;
  logic        m_fv, m_flush, m_mis, m_pend;

  function automatic logic [32:0] choose(input logic pv, input logic [31:0] pt,
                                         input logic jj, input logic [31:0] jjt,
                                         input logic bb, input logic [31:0] bbt);
    if (pv) return {1'b1, pt};
    if (jj) return {1'b1, jjt};
    if (bb) return {1'b1, bbt};
    return 33'd0;
  endfunction

  logic [32:0] m_sel;
  assign m_sel = choose(m_pend, m_pend_tgt, j, jt, br, bt);

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_pc <= 32'h0; m_fv <= 1'b0; m_flush <= 1'b0; m_mis <= 1'b0; m_pend <= 1'b0;
    end else if (!m_fv) begin
      m_fv <= 1'b1; m_flush <= 1'b0; m_mis <= 1'b0;
    end else if (st) begin
      m_flush <= 1'b0; m_mis <= 1'b0;
      if (!m_pend && (j || br)) begin
        m_pend     <= 1'b1;
        m_pend_tgt <= j ? jt : bt;
      end
    end else begin
      m_pend <= 1'b0;
      if (m_sel[32]) begin
        m_pc    <= {m_sel[31:2], 2'b00};
        m_flush <= 1'b1;
        m_mis   <= (m_sel[1:0] != 2'b00);
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_flush <= 1'b0;
        m_mis   <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    if (run_cmp) begin
      chk("pc_a",    ifa.PCResult,   m_pc);
      chk("fv_a",    ifa.FetchValid, m_fv);
      chk("flush_a", ifa.Flush,      m_flush);
      chk("mis_a",   ifa.Misaligned, m_mis);
      chk("pc_b",    ifb.PCResult,   m_pc);
      chk("fv_b",    ifb.FetchValid, m_fv);
      chk("flush_b", ifb.Flush,      m_flush);
      chk("mis_b",   ifb.Misaligned, 32'd0);
    end
  end

  task automatic cyc(input logic b, input logic [31:0] btv,
                     input logic jj, input logic [31:0] jtv, input logic s);
    br = b; bt = btv; j = jj; jt = jtv; st = s;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    br = 1'b0; bt = 32'h0; j = 1'b0; jt = 32'h0; st = 1'b0;
    repeat (2) @(negedge Clk);
    run_cmp = 1'b1;
    chk("rst_pc", ifa.PCResult, 32'h0);
    chk("rst_fv", ifa.FetchValid, 32'd0);
    chk("rst_flush", ifa.Flush, 32'd0);
    Reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("boot_fv", ifa.FetchValid, 32'd1);
    chk("boot_pc", ifa.PCResult, 32'h0);
    cyc(0, 0, 0, 0, 0); chk("seq4", ifa.PCResult, 32'h4);
    cyc(0, 0, 0, 0, 0); chk("seq8", ifa.PCResult, 32'h8);
    cyc(0, 0, 0, 0, 0); chk("seq12", ifa.PCResult, 32'hC);
    cyc(0, 0, 0, 0, 0); chk("seq16", ifa.PCResult, 32'h10);
    cyc(1, 32'h40, 0, 0, 0);
    chk("br_pc", ifa.PCResult, 32'h40);
    chk("br_flush", ifa.Flush, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("br_next", ifa.PCResult, 32'h44);
    chk("br_flush_end", ifa.Flush, 32'd0);
    cyc(1, 32'h40, 1, 32'h100, 0);
    chk("jmp_win", ifa.PCResult, 32'h100);
    chk("jmp_flush", ifa.Flush, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("jmp_next", ifa.PCResult, 32'h104);
    cyc(1, 32'h80, 0, 0, 1);
    chk("stall1_pc", ifa.PCResult, 32'h104);
    chk("stall1_flush", ifa.Flush, 32'd0);
    cyc(0, 0, 1, 32'h200, 1); chk("stall2_pc", ifa.PCResult, 32'h104);
    cyc(0, 0, 0, 0, 1);       chk("stall3_pc", ifa.PCResult, 32'h104);
    cyc(0, 0, 0, 0, 0);
    chk("release_pc", ifa.PCResult, 32'h80);
    chk("release_flush", ifa.Flush, 32'd1);
    cyc(0, 0, 0, 0, 0); chk("release_next", ifa.PCResult, 32'h84);
    cyc(1, 32'h43, 0, 0, 0);
    chk("mis_pc", ifa.PCResult, 32'h40);
    chk("mis_a_pulse", ifa.Misaligned, 32'd1);
    chk("mis_b_quiet", ifb.Misaligned, 32'd0);
    cyc(0, 0, 0, 0, 0); chk("mis_end", ifa.Misaligned, 32'd0);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0); chk("top_pc", ifa.PCResult, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);             chk("wrap_pc", ifa.PCResult, 32'h0);
    cyc(1, 32'h300, 0, 0, 1);       chk("pend_hold", ifa.PCResult, 32'h0);
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("rst2_pc", ifa.PCResult, 32'h0);
    chk("rst2_fv", ifa.FetchValid, 32'd0);
    Reset = 1'b0;
    cyc(0, 0, 0, 0, 0); chk("rst2_boot", ifa.PCResult, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("rst2_no_pend", ifa.PCResult, 32'h4);
    chk("rst2_no_flush", ifa.Flush, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t1, t2;
      t1 = $urandom;
      t2 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) t2[1:0] = 2'b00;
      Reset = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 4) == 0, t1, $urandom_range(0, 9) == 0, t2,
          $urandom_range(0, 9) < 3);
    end

    run_cmp = 1'b0;
    Reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
